// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Load-use stall, taken-branch squash and ECALL/EBREAK
//               drain/halt control for the RV32I five-stage pipeline.
//               Define HAZARD_PERF_CNT_EN to build the stall/flush counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             id_halt_req,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_rd,
    input  logic             ex_br_taken,
    input  logic             resume,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             halted,
    output logic [CNT_W-1:0] cnt_stall,
    output logic [CNT_W-1:0] cnt_flush
);

    localparam int                c_dcnt_w    = $clog2(DRAIN_CYCLES + 1);
    localparam logic [c_dcnt_w-1:0] c_dcnt_init = c_dcnt_w'(DRAIN_CYCLES);
    localparam logic [c_dcnt_w-1:0] c_dcnt_one  = c_dcnt_w'(1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_dcnt_w-1:0] r_dcnt;
    logic [c_dcnt_w-1:0] w_dcnt_nxt;
    logic                w_luh;
    logic                w_run;

    assign w_luh = ex_mem_rd && (ex_rd != 5'd0) &&
                   ((id_use_rs1 && (ex_rd == id_rs1)) ||
                    (id_use_rs2 && (ex_rd == id_rs2)));
    assign w_run = (r_state == ST_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_dcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dcnt  <= w_dcnt_nxt;
        end
    end

    always_comb begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        if_id_flush = 1'b0;
        id_ex_en    = 1'b0;
        id_ex_flush = 1'b0;
        halted      = 1'b0;
        w_state_nxt = r_state;
        w_dcnt_nxt  = r_dcnt;
        if (!rst) begin
            case (r_state)
                ST_RUN: begin
                    // A taken branch squashes the ID instruction, so any hazard
                    // or halt request it carries is moot.
                    if (ex_br_taken) begin
                        pc_en       = 1'b1;
                        if_id_en    = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_en    = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (w_luh) begin
                        id_ex_en    = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (id_halt_req) begin
                        id_ex_en    = 1'b1;
                        w_state_nxt = ST_DRAIN;
                        w_dcnt_nxt  = c_dcnt_init;
                    end else begin
                        pc_en       = 1'b1;
                        if_id_en    = 1'b1;
                        id_ex_en    = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    id_ex_en    = 1'b1;
                    id_ex_flush = 1'b1;
                    w_dcnt_nxt  = r_dcnt - c_dcnt_one;
                    if (r_dcnt <= c_dcnt_one) begin
                        w_state_nxt = ST_HALTED;
                        w_dcnt_nxt  = '0;
                    end
                end
                ST_HALTED: begin
                    halted = 1'b1;
                    if (resume) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                default: begin
                    w_state_nxt = ST_RUN;
                    w_dcnt_nxt  = '0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt_stall;
    logic [CNT_W-1:0] r_cnt_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_stall <= '0;
            r_cnt_flush <= '0;
        end else begin
            if (w_run && ex_br_taken) begin
                r_cnt_flush <= r_cnt_flush + c_cnt_one;
            end
            if (w_run && w_luh && !ex_br_taken) begin
                r_cnt_stall <= r_cnt_stall + c_cnt_one;
            end
        end
    end

    assign cnt_stall = r_cnt_stall;
    assign cnt_flush = r_cnt_flush;
`else
    logic w_unused;
    assign w_unused  = w_run;
    assign cnt_stall = '0;
    assign cnt_flush = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed plus random stimulus for hazard_ctrl against a
//               cycle-indexed reference model of the pipeline control rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int c_drain = 3;
    localparam int c_cnt_w = 4;
    localparam int c_mask  = (1 << c_cnt_w) - 1;
    localparam int M_RUN    = 0;
    localparam int M_DRAIN  = 1;
    localparam int M_HALTED = 2;

    logic               clk;
    logic               rst;
    logic [4:0]         id_rs1, id_rs2, ex_rd;
    logic               id_use_rs1, id_use_rs2, id_halt_req;
    logic               ex_mem_rd, ex_br_taken, resume;
    logic               pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, halted;
    logic [c_cnt_w-1:0] cnt_stall, cnt_flush;

    hazard_ctrl #(.DRAIN_CYCLES(c_drain), .CNT_W(c_cnt_w)) u_dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_halt_req(id_halt_req), .ex_rd(ex_rd), .ex_mem_rd(ex_mem_rd),
        .ex_br_taken(ex_br_taken), .resume(resume),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .halted(halted),
        .cnt_stall(cnt_stall), .cnt_flush(cnt_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: the halt sequence is tracked by the cycle index at
    // which the halt request was accepted.
    int cyc       = 0;
    bit halting   = 0;
    int halt_cyc  = 0;
    int m_stall   = 0;
    int m_flush   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int mode_now();
        int elapsed;
        if (!halting) return M_RUN;
        elapsed = cyc - halt_cyc;
        return (elapsed <= c_drain) ? M_DRAIN : M_HALTED;
    endfunction

    function automatic bit luh_now();
        return ex_mem_rd && (ex_rd != 0) &&
               ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
    endfunction

    // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, halted}
    function automatic logic [5:0] exp_outs();
        int m;
        m = mode_now();
        if (rst) return 6'b000000;
        if (m == M_DRAIN) return 6'b000110;
        if (m == M_HALTED) return 6'b000001;
        if (ex_br_taken) return 6'b111110;
        if (luh_now()) return 6'b000110;
        if (id_halt_req) return 6'b000100;
        return 6'b110100;
    endfunction

    function automatic int exp_cnt(input int v);
`ifdef HAZARD_PERF_CNT_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    task automatic model_edge();
        int m;
        m = mode_now();
        if (rst) begin
            halting = 0;
            m_stall = 0;
            m_flush = 0;
        end else if (m == M_RUN) begin
            if (ex_br_taken) m_flush = (m_flush + 1) & c_mask;
            else if (luh_now()) m_stall = (m_stall + 1) & c_mask;
            else if (id_halt_req) begin
                halting  = 1;
                halt_cyc = cyc;
            end
        end else if (m == M_HALTED && resume) begin
            halting = 0;
        end
        cyc++;
    endtask

    task automatic cycle(input string tag);
        @(negedge clk);
        check({tag, ".outs"}, 32'({pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, halted}),
              32'(exp_outs()));
        check({tag, ".cnt_stall"}, 32'(cnt_stall), 32'(exp_cnt(m_stall)));
        check({tag, ".cnt_flush"}, 32'(cnt_flush), 32'(exp_cnt(m_flush)));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        rst = 0; id_rs1 = 5'd1; id_rs2 = 5'd2; id_use_rs1 = 1; id_use_rs2 = 1;
        id_halt_req = 0; ex_rd = 5'd7; ex_mem_rd = 0; ex_br_taken = 0; resume = 0;
    endtask

    initial begin
        idle();
        rst = 1;
        @(posedge clk);
        model_edge();
        #1;
        cycle("reset");
        cycle("reset");
        idle();
        cycle("idle");
        cycle("idle");

        ex_mem_rd = 1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1;
        cycle("load_use");
        idle();
        cycle("after_load_use");

        ex_mem_rd = 1; ex_rd = 5'd0; id_rs2 = 5'd0; id_use_rs2 = 1;
        cycle("x0_load");
        idle();

        ex_mem_rd = 1; ex_rd = 5'd9; id_rs1 = 5'd9; ex_br_taken = 1;
        cycle("luh_and_branch");
        idle();

        resume = 1;
        cycle("resume_in_run");
        idle();
        id_halt_req = 1;
        cycle("halt_req");
        id_halt_req = 0;
        ex_br_taken = 1; ex_mem_rd = 1; ex_rd = 5'd1;
        cycle("drain1");
        idle();
        cycle("drain2");
        cycle("drain3");
        for (int i = 0; i < 3; i++) cycle("halted_hold");
        resume = 1;
        cycle("resume");
        idle();
        cycle("after_resume");

        id_halt_req = 1;
        cycle("halt_req2");
        id_halt_req = 0;
        cycle("drain1b");
        rst = 1;
        cycle("rst_mid_drain");
        rst = 0;
        cycle("after_rst");
        cycle("after_rst2");

        ex_br_taken = 1;
        for (int i = 0; i < 17; i++) cycle("flush_wrap");
        idle();
        cycle("after_wrap");

        for (int i = 0; i < 400; i++) begin
            rst         = ($urandom_range(0, 49) == 0);
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            ex_rd       = 5'($urandom_range(0, 3));
            id_use_rs1  = 1'($urandom_range(0, 1));
            id_use_rs2  = 1'($urandom_range(0, 1));
            ex_mem_rd   = 1'($urandom_range(0, 1));
            ex_br_taken = ($urandom_range(0, 4) == 0);
            id_halt_req = ($urandom_range(0, 9) == 0);
            resume      = ($urandom_range(0, 3) == 0);
            cycle("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
